launch_queue: RTL and testbench

LAUNCH_QUEUE -- requirements
Module: launch_queue

---
 rtl/launch_queue_pkg.sv | 29 ++
 rtl/lq_operand_fwd.sv | 37 +++
 rtl/launch_queue.sv | 171 +++++++++++++++++
 tb/tb_launch_queue.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/launch_queue_pkg.sv
// Shared field layout, instruction types and forwarding-bus geometry for launch_queue.
package launch_queue_pkg;

  localparam int unsigned DECODEOUT_W = 32;
  localparam int unsigned RA_W        = 5;

  // Decode bundle field positions
  localparam int unsigned DC_RS_LSB   = 0;
  localparam int unsigned DC_RSV      = 5;
  localparam int unsigned DC_RT_LSB   = 6;
  localparam int unsigned DC_RTV      = 11;
  localparam int unsigned DC_RD_LSB   = 12;
  localparam int unsigned DC_RDV      = 17;
  localparam int unsigned DC_TYPE_LSB = 18;
  localparam int unsigned DC_TYPE_W   = 3;

  // Forwarding entry is {enable, complete, addr, data}; control bits above data
  localparam int unsigned FWD_CTRL_W  = 2 + RA_W;

  localparam logic [31:0] DATA_INITIAL = 32'h0;

  typedef enum logic [2:0] {
    INSTTYPE_ALU = 3'd0,
    INSTTYPE_BR  = 3'd1,
    INSTTYPE_AG  = 3'd2,
    INSTTYPE_MUL = 3'd3
  } insttype_e;

endpackage

// File: rtl/lq_operand_fwd.sv
// Resolves one source operand from forwarding buses or the register file.
module lq_operand_fwd
  import launch_queue_pkg::*;
#(
  parameter int unsigned DW   = 32,
  parameter int unsigned NFWD = 4
) (
  input  logic                              v_i,
  input  logic [RA_W-1:0]                   addr_i,
  input  logic [DW-1:0]                     rf_data_i,
  input  logic [NFWD*(DW+FWD_CTRL_W)-1:0]   fwd_i,
  output logic [DW-1:0]                     data_o,
  output logic                              ready_o
);

  localparam int unsigned RFW = DW + FWD_CTRL_W;

  logic hit;

  // Lowest-index enabled match wins; x0 and unused operands are always ready zero
  always_comb begin
    data_o  = '0;
    ready_o = 1'b1;
    hit     = 1'b0;
    if (v_i && (addr_i != '0)) begin
      data_o = rf_data_i;
      for (int k = 0; k < int'(NFWD); k++) begin
        if (!hit && fwd_i[k*RFW + RFW - 1] && (fwd_i[k*RFW + DW +: RA_W] == addr_i)) begin
          hit     = 1'b1;
          data_o  = fwd_i[k*RFW +: DW];
          ready_o = fwd_i[k*RFW + RFW - 2];
        end
      end
    end
  end

endmodule

// File: rtl/launch_queue.sv
// In-order dual-issue launch queue feeding an ALU/branch unit (A) and an AG unit (B).
module launch_queue
  import launch_queue_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned NFWD  = 4,
  parameter int unsigned DW    = 32,
  parameter int unsigned PCW   = 32,
  parameter int unsigned DCW   = DECODEOUT_W
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            flush,
  input  logic                            stop,
  input  logic [1:0]                      in_valid,
  input  logic [2*PCW-1:0]                in_pc,
  input  logic [2*PCW-1:0]                in_npc,
  input  logic [2*DCW-1:0]                in_decodeout,
  output logic                            in_ready,
  output logic [4*RA_W-1:0]               rf_raddr,
  input  logic [4*DW-1:0]                 rf_rdata,
  input  logic [NFWD*(DW+FWD_CTRL_W)-1:0] fwd,
  output logic                            exA_valid,
  input  logic                            exA_ready,
  output logic                            exA_num,
  output logic [PCW-1:0]                  exA_pc,
  output logic [PCW-1:0]                  exA_npc,
  output logic [DCW-1:0]                  exA_decodeout,
  output logic [DW-1:0]                   exA_rdata1,
  output logic [DW-1:0]                   exA_rdata2,
  output logic                            exB_valid,
  input  logic                            exB_ready,
  output logic                            exB_num,
  output logic [PCW-1:0]                  exB_pc,
  output logic [PCW-1:0]                  exB_npc,
  output logic [DCW-1:0]                  exB_decodeout,
  output logic [DW-1:0]                   exB_rdata1,
  output logic [DW-1:0]                   exB_rdata2
);

  localparam int unsigned PTRW = $clog2(DEPTH);
  localparam int unsigned CNTW = PTRW + 1;

  logic [PCW-1:0]  pc_q  [DEPTH];
  logic [PCW-1:0]  npc_q [DEPTH];
  logic [DCW-1:0]  dc_q  [DEPTH];

  logic [PTRW-1:0] head_q, head_d, tail_q, tail_d, head1, tail1;
  logic [CNTW-1:0] count_q, count_d;

  logic [DCW-1:0]  dc0, dc1;
  logic [3:0]      op_v, op_rdy;
  logic [RA_W-1:0] op_addr [4];
  logic [DW-1:0]   op_data [4];

  logic            unit_b0, unit_b1, raw_hazard, hold;
  logic            cand0, cand1, fire0, fire1, enq;
  logic [1:0]      n_enq, n_iss;

  assign head1 = head_q + PTRW'(1);
  assign tail1 = tail_q + PTRW'(1);
  assign dc0   = dc_q[head_q];
  assign dc1   = dc_q[head1];

  assign op_v       = {dc1[DC_RTV], dc1[DC_RSV], dc0[DC_RTV], dc0[DC_RSV]};
  assign op_addr[0] = dc0[DC_RS_LSB +: RA_W];
  assign op_addr[1] = dc0[DC_RT_LSB +: RA_W];
  assign op_addr[2] = dc1[DC_RS_LSB +: RA_W];
  assign op_addr[3] = dc1[DC_RT_LSB +: RA_W];

  // Operands 0/1 belong to head, 2/3 to head+1 (rs, rt order)
  for (genvar g = 0; g < 4; g++) begin : g_op
    assign rf_raddr[g*RA_W +: RA_W] = op_addr[g];
    lq_operand_fwd #(.DW(DW), .NFWD(NFWD)) u_op (
      .v_i       (op_v[g]),
      .addr_i    (op_addr[g]),
      .rf_data_i (rf_rdata[g*DW +: DW]),
      .fwd_i     (fwd),
      .data_o    (op_data[g]),
      .ready_o   (op_rdy[g])
    );
  end

  assign unit_b0 = (dc0[DC_TYPE_LSB +: DC_TYPE_W] == INSTTYPE_AG);
  assign unit_b1 = (dc1[DC_TYPE_LSB +: DC_TYPE_W] == INSTTYPE_AG);

  // Head+1 must not read a register the head is about to write
  assign raw_hazard = dc0[DC_RDV] && (dc0[DC_RD_LSB +: RA_W] != '0) &&
                      ((dc1[DC_RSV] && (op_addr[2] == dc0[DC_RD_LSB +: RA_W])) ||
                       (dc1[DC_RTV] && (op_addr[3] == dc0[DC_RD_LSB +: RA_W])));

  assign hold  = flush || stop;
  assign cand0 = !hold && (count_q != '0) && op_rdy[0] && op_rdy[1];
  assign fire0 = cand0 && (unit_b0 ? exB_ready : exA_ready);
  assign cand1 = fire0 && (count_q >= CNTW'(2)) && (unit_b1 != unit_b0) &&
                 op_rdy[2] && op_rdy[3] && !raw_hazard;
  assign fire1 = cand1 && (unit_b1 ? exB_ready : exA_ready);
  assign n_iss = {1'b0, fire0} + {1'b0, fire1};

  assign in_ready = !stop && (count_q <= CNTW'(DEPTH - 2));
  assign enq      = in_ready && !flush;
  assign n_enq    = enq ? ({1'b0, in_valid[0]} + {1'b0, in_valid[1]}) : 2'd0;

  // Route head / head+1 onto their target units; idle ports carry zeros
  always_comb begin
    exA_valid = 1'b0; exA_num = 1'b0; exA_pc = '0; exA_npc = '0;
    exA_decodeout = '0; exA_rdata1 = DW'(DATA_INITIAL); exA_rdata2 = DW'(DATA_INITIAL);
    exB_valid = 1'b0; exB_num = 1'b0; exB_pc = '0; exB_npc = '0;
    exB_decodeout = '0; exB_rdata1 = DW'(DATA_INITIAL); exB_rdata2 = DW'(DATA_INITIAL);
    if (cand0 && !unit_b0) begin
      exA_valid = 1'b1; exA_pc = pc_q[head_q]; exA_npc = npc_q[head_q];
      exA_decodeout = dc0; exA_rdata1 = op_data[0]; exA_rdata2 = op_data[1];
    end
    if (cand0 && unit_b0) begin
      exB_valid = 1'b1; exB_pc = pc_q[head_q]; exB_npc = npc_q[head_q];
      exB_decodeout = dc0; exB_rdata1 = op_data[0]; exB_rdata2 = op_data[1];
    end
    if (cand1 && !unit_b1) begin
      exA_valid = 1'b1; exA_num = 1'b1; exA_pc = pc_q[head1]; exA_npc = npc_q[head1];
      exA_decodeout = dc1; exA_rdata1 = op_data[2]; exA_rdata2 = op_data[3];
    end
    if (cand1 && unit_b1) begin
      exB_valid = 1'b1; exB_num = 1'b1; exB_pc = pc_q[head1]; exB_npc = npc_q[head1];
      exB_decodeout = dc1; exB_rdata1 = op_data[2]; exB_rdata2 = op_data[3];
    end
  end

  // Pointer and occupancy update; flush overrides everything
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      head_d  = head_q + PTRW'(n_iss);
      tail_d  = tail_q + PTRW'(n_enq);
      count_d = count_q + CNTW'(n_enq) - CNTW'(n_iss);
    end
  end

  // Control state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry storage; contents are don't-care while the count says empty
  always_ff @(posedge clk) begin
    if (enq && in_valid[0]) begin
      pc_q[tail_q]  <= in_pc[0 +: PCW];
      npc_q[tail_q] <= in_npc[0 +: PCW];
      dc_q[tail_q]  <= in_decodeout[0 +: DCW];
    end
    if (enq && in_valid[1]) begin
      pc_q[tail1]   <= in_pc[PCW +: PCW];
      npc_q[tail1]  <= in_npc[PCW +: PCW];
      dc_q[tail1]   <= in_decodeout[DCW +: DCW];
    end
  end

endmodule

// File: tb/tb_launch_queue.sv
// Directed bench for launch_queue with a simple register-file model (x[n] = n + 4).
module tb_launch_queue;
  import launch_queue_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned NFWD  = 4;
  localparam int unsigned DW    = 32;
  localparam int unsigned PCW   = 32;
  localparam int unsigned DCW   = 32;
  localparam int unsigned RFW   = DW + FWD_CTRL_W;

  logic                   clk, rst, flush, stop;
  logic [1:0]             in_valid;
  logic [2*PCW-1:0]       in_pc, in_npc;
  logic [2*DCW-1:0]       in_decodeout;
  logic                   in_ready;
  logic [4*RA_W-1:0]      rf_raddr;
  logic [4*DW-1:0]        rf_rdata;
  logic [NFWD*RFW-1:0]    fwd;
  logic                   exA_valid, exA_ready, exA_num;
  logic [PCW-1:0]         exA_pc, exA_npc;
  logic [DCW-1:0]         exA_decodeout;
  logic [DW-1:0]          exA_rdata1, exA_rdata2;
  logic                   exB_valid, exB_ready, exB_num;
  logic [PCW-1:0]         exB_pc, exB_npc;
  logic [DCW-1:0]         exB_decodeout;
  logic [DW-1:0]          exB_rdata1, exB_rdata2;

  int total = 0;
  int bad   = 0;

  launch_queue #(.DEPTH(DEPTH), .NFWD(NFWD), .DW(DW), .PCW(PCW), .DCW(DCW)) dut (
    .clk(clk), .rst(rst), .flush(flush), .stop(stop),
    .in_valid(in_valid), .in_pc(in_pc), .in_npc(in_npc), .in_decodeout(in_decodeout),
    .in_ready(in_ready), .rf_raddr(rf_raddr), .rf_rdata(rf_rdata), .fwd(fwd),
    .exA_valid(exA_valid), .exA_ready(exA_ready), .exA_num(exA_num),
    .exA_pc(exA_pc), .exA_npc(exA_npc), .exA_decodeout(exA_decodeout),
    .exA_rdata1(exA_rdata1), .exA_rdata2(exA_rdata2),
    .exB_valid(exB_valid), .exB_ready(exB_ready), .exB_num(exB_num),
    .exB_pc(exB_pc), .exB_npc(exB_npc), .exB_decodeout(exB_decodeout),
    .exB_rdata1(exB_rdata1), .exB_rdata2(exB_rdata2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file model: every address reads addr+4 (x0 included, DUT must zero it)
  always_comb begin
    rf_rdata = '0;
    for (int g = 0; g < 4; g++)
      rf_rdata[g*DW +: DW] = DW'(rf_raddr[g*RA_W +: RA_W]) + DW'(4);
  end

  // Younger-only decode slot is illegal
  always @(posedge clk)
    if (rst) assert (in_valid != 2'b10) else $error("illegal in_valid 2'b10");

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DCW-1:0] mk_dc(input logic [2:0] ty,
                                           input logic [4:0] rs, input logic rsv,
                                           input logic [4:0] rt, input logic rtv,
                                           input logic [4:0] rd, input logic rdv);
    logic [DCW-1:0] d;
    d = '0;
    d[DC_RS_LSB +: 5] = rs;  d[DC_RSV] = rsv;
    d[DC_RT_LSB +: 5] = rt;  d[DC_RTV] = rtv;
    d[DC_RD_LSB +: 5] = rd;  d[DC_RDV] = rdv;
    d[DC_TYPE_LSB +: 3] = ty;
    return d;
  endfunction

  task automatic put(input logic [1:0] v, input logic [DCW-1:0] d0, input logic [PCW-1:0] p0,
                     input logic [DCW-1:0] d1, input logic [PCW-1:0] p1);
    in_valid     = v;
    in_decodeout = {d1, d0};
    in_pc        = {p1, p0};
    in_npc       = {p1 + 32'd4, p0 + 32'd4};
  endtask

  task automatic set_fwd(input int k, input logic en, input logic cp,
                         input logic [4:0] a, input logic [DW-1:0] d);
    fwd[k*RFW +: RFW] = {en, cp, a, d};
  endtask

  task automatic next_cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  logic [DCW-1:0] alu1, ag2;

  initial begin
    rst = 1'b0; flush = 1'b0; stop = 1'b0;
    in_valid = '0; in_pc = '0; in_npc = '0; in_decodeout = '0;
    fwd = '0; exA_ready = 1'b1; exB_ready = 1'b1;
    alu1 = mk_dc(INSTTYPE_ALU, 5'd1, 1'b1, 5'd0, 1'b0, 5'd10, 1'b1);
    ag2  = mk_dc(INSTTYPE_AG,  5'd2, 1'b1, 5'd0, 1'b0, 5'd11, 1'b1);

    // Reset values
    #12;
    check("rst_exA_valid", exA_valid, 0);
    check("rst_exB_valid", exB_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_exA_pc", exA_pc, 0);
    check("rst_exB_rdata1", exB_rdata1, 0);
    @(negedge clk);
    rst = 1'b1;

    // Dual issue ALU x1 + AG x2 from the RF
    put(2'b11, alu1, 32'h100, ag2, 32'h104);
    #1 check("t1_in_ready", in_ready, 1);
    check("t1_empty_valid", exA_valid, 0);
    next_cycle(); in_valid = 2'b00;
    #1 check("t1_exA_valid", exA_valid, 1);
    check("t1_exB_valid", exB_valid, 1);
    check("t1_exA_num", exA_num, 0);
    check("t1_exB_num", exB_num, 1);
    check("t1_exA_rdata1", exA_rdata1, 5);
    check("t1_exB_rdata1", exB_rdata1, 6);
    check("t1_exA_rdata2", exA_rdata2, 0);
    check("t1_exA_pc", exA_pc, 32'h100);
    check("t1_exB_npc", exB_npc, 32'h108);
    next_cycle();
    #1 check("t1_drained_A", exA_valid, 0);
    check("t1_drained_B", exB_valid, 0);

    // Forwarding priority, and x0 never forwarded
    put(2'b01, mk_dc(INSTTYPE_ALU, 5'd3, 1'b1, 5'd0, 1'b1, 5'd0, 1'b0), 32'h110, '0, '0);
    set_fwd(0, 1'b1, 1'b0, 5'd0, 32'h99);
    set_fwd(1, 1'b1, 1'b1, 5'd3, 32'h11);
    set_fwd(2, 1'b1, 1'b1, 5'd3, 32'h22);
    next_cycle(); in_valid = 2'b00;
    #1 check("t2_exA_valid", exA_valid, 1);
    check("t2_fwd_prio", exA_rdata1, 32'h11);
    check("t2_x0_zero", exA_rdata2, 0);
    check("t2_exB_pc_idle", exB_pc, 0);
    next_cycle(); fwd = '0;

    // Incomplete forward stalls until complete
    put(2'b01, mk_dc(INSTTYPE_ALU, 5'd4, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0), 32'h120, '0, '0);
    set_fwd(0, 1'b1, 1'b0, 5'd4, 32'h44);
    next_cycle(); in_valid = 2'b00;
    #1 check("t3_stall_valid", exA_valid, 0);
    check("t3_stall_payload", exA_rdata1, 0);
    next_cycle(); set_fwd(0, 1'b1, 1'b1, 5'd4, 32'h44);
    #1 check("t3_go_valid", exA_valid, 1);
    check("t3_go_data", exA_rdata1, 32'h44);
    check("t3_go_pc", exA_pc, 32'h120);
    next_cycle(); fwd = '0;
    #1 check("t3_done", exA_valid, 0);

    // RAW between head and head+1
    put(2'b11, mk_dc(INSTTYPE_ALU, 5'd1, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1), 32'h130,
               mk_dc(INSTTYPE_AG,  5'd7, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0), 32'h134);
    next_cycle(); in_valid = 2'b00;
    #1 check("t4_head_A", exA_valid, 1);
    check("t4_hold_B", exB_valid, 0);
    next_cycle();
    #1 check("t4_B_valid", exB_valid, 1);
    check("t4_B_num", exB_num, 0);
    check("t4_B_data", exB_rdata1, 11);
    check("t4_B_pc", exB_pc, 32'h134);
    check("t4_A_idle", exA_valid, 0);
    next_cycle();

    // Fill to DEPTH-1 with unit A blocked, then drain across the wrap
    exA_ready = 1'b0;
    put(2'b11, alu1, 32'h200, alu1, 32'h204);
    next_cycle();
    put(2'b01, alu1, 32'h208, '0, '0);
    #1 check("t5_ready_at2", in_ready, 1);
    next_cycle();
    put(2'b11, alu1, 32'h300, alu1, 32'h304);
    #1 check("t5_full_ready", in_ready, 0);
    check("t5_head_valid", exA_valid, 1);
    check("t5_head_pc", exA_pc, 32'h200);
    next_cycle(); in_valid = 2'b00; exA_ready = 1'b1;
    #1 check("t5_pc0", exA_pc, 32'h200);
    check("t5_ready_busy", in_ready, 0);
    next_cycle();
    put(2'b01, alu1, 32'h20C, '0, '0);
    #1 check("t5_pc1", exA_pc, 32'h204);
    check("t5_ready_again", in_ready, 1);
    check("t5_no_dual", exB_valid, 0);
    next_cycle(); in_valid = 2'b00;
    #1 check("t5_pc2", exA_pc, 32'h208);
    next_cycle();
    #1 check("t5_pc3", exA_pc, 32'h20C);
    next_cycle();
    #1 check("t5_empty", exA_valid, 0);

    // Flush with three entries held and a pending dual enqueue
    exA_ready = 1'b0;
    put(2'b11, alu1, 32'h400, alu1, 32'h404);
    next_cycle();
    put(2'b01, alu1, 32'h408, '0, '0);
    next_cycle();
    flush = 1'b1; exA_ready = 1'b1;
    put(2'b11, alu1, 32'h500, alu1, 32'h504);
    #1 check("t6_flush_A", exA_valid, 0);
    check("t6_flush_B", exB_valid, 0);
    next_cycle(); flush = 1'b0; in_valid = 2'b00;
    #1 check("t6_after_A", exA_valid, 0);
    check("t6_after_ready", in_ready, 1);
    put(2'b01, ag2, 32'h600, '0, '0);
    next_cycle(); in_valid = 2'b00;
    #1 check("t6_B_valid", exB_valid, 1);
    check("t6_B_pc", exB_pc, 32'h600);
    check("t6_B_num", exB_num, 0);
    next_cycle();

    // Stop freezes issue and enqueue
    exA_ready = 1'b0;
    put(2'b01, alu1, 32'h700, '0, '0);
    next_cycle(); in_valid = 2'b00; stop = 1'b1; exA_ready = 1'b1;
    #1 check("t7_stop_valid", exA_valid, 0);
    check("t7_stop_ready", in_ready, 0);
    check("t7_stop_pc", exA_pc, 0);
    next_cycle(); stop = 1'b0;
    #1 check("t7_go_valid", exA_valid, 1);
    check("t7_go_pc", exA_pc, 32'h700);
    next_cycle();

    // Reset mid-operation drops entries immediately
    exA_ready = 1'b0; exB_ready = 1'b0;
    put(2'b11, alu1, 32'h800, ag2, 32'h804);
    next_cycle(); in_valid = 2'b00;
    #1 check("t8_pre_A", exA_valid, 1);
    check("t8_pre_B", exB_valid, 0);
    rst = 1'b0;
    #1 check("t8_rst_A", exA_valid, 0);
    check("t8_rst_B", exB_valid, 0);
    check("t8_rst_ready", in_ready, 1);
    check("t8_rst_pc", exA_pc, 0);
    next_cycle(); rst = 1'b1; exA_ready = 1'b1; exB_ready = 1'b1;
    #1 check("t8_post_A", exA_valid, 0);
    check("t8_post_B", exB_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
